// File: rtl/vga_text_pkg.sv
// Shared types and constants for the debug-display text fetch path.
// Optional feature macro: VGA_ROW_LABEL_EN (prefix each row with "HH:").
package vga_text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_EMIT,
    ST_NEXT
  } fetch_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam int FIELD_W     = 32;
  localparam int FIELDS      = 4;
  localparam int FIELD_CHARS = 9;

`ifdef VGA_ROW_LABEL_EN
  localparam int LABEL_CHARS = 3;
`else
  localparam int LABEL_CHARS = 0;
`endif

  localparam int CHARS_PER_ROW = FIELDS * FIELD_CHARS + LABEL_CHARS;

endpackage

// File: rtl/vga_hex_char.sv
// Nibble to uppercase ASCII hex encoder; blank forces a space.
module vga_hex_char
  import vga_text_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] ascii
);

  // Pure lookup: digits 0-9 then A-F, space when blanked
  always_comb begin
    ascii = ASCII_SPACE;
    if (!blank) begin
      if (nibble < 4'd10) begin
        ascii = ASCII_ZERO + {4'b0000, nibble};
      end else begin
        ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
      end
    end
  end

endmodule

// File: rtl/vga_hex_row_fetch.sv
// Walks the debug-display RAM once per frame and streams each 128-bit row
// as ASCII hex characters (with row/column) over a valid/ready handshake.
// Optional feature macro: VGA_ROW_LABEL_EN adds a "HH:" row label.
module vga_hex_row_fetch
  import vga_text_pkg::*;
#(
  parameter int NUM_ROWS        = 46,
  parameter int REG_ROWS        = 32,
  parameter int CHARS_PER_FIELD = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  output logic [5:0]   read_address,
  input  logic [127:0] ram_out,
  output logic         char_valid,
  input  logic         char_ready,
  output logic [7:0]   char_data,
  output logic [5:0]   char_col,
  output logic [5:0]   char_row,
  output logic         busy,
  output logic         frame_done
);

  localparam int         ROW_CHARS  = FIELDS * CHARS_PER_FIELD + LABEL_CHARS;
  localparam logic [5:0] LAST_COL   = 6'(ROW_CHARS - 1);
  localparam logic [5:0] LAST_ROW   = 6'(NUM_ROWS - 1);
  localparam logic [3:0] LAST_DIGIT = 4'(CHARS_PER_FIELD - 1);

  fetch_state_t   state_q, state_d;
  logic [5:0]     row_q, row_d;
  logic [5:0]     col_q, col_d;
  logic [1:0]     field_q, field_d;   // which 32-bit field is printing
  logic [3:0]     digit_q, digit_d;   // position inside field, last = space
  logic [127:0]   row_word_q, row_word_d;

  logic [FIELD_W-1:0] field_words [FIELDS];
  logic [FIELD_W-1:0] field_word;
  logic [FIELD_W-1:0] field_shift;
  logic [3:0]         enc_nibble;
  logic               enc_blank;
  logic [7:0]         enc_ascii;
  logic               row_blank;
  logic               emit_fire;
`ifdef VGA_ROW_LABEL_EN
  logic               in_label;
  logic               label_colon;
`endif

  // Split the latched word into fields, instr in the top slice
  for (genvar gi = 0; gi < FIELDS; gi++) begin : g_fields
    assign field_words[gi] = row_word_q[(FIELDS-1-gi)*FIELD_W +: FIELD_W];
  end

  assign field_word  = field_words[field_q];
  assign field_shift = field_word << {digit_q[2:0], 2'b00};
  // Rows past the register file alias RAM contents, so reg/float are hidden
  assign row_blank   = int'(row_q) >= REG_ROWS;
  assign emit_fire   = (state_q == ST_EMIT) && char_ready;
`ifdef VGA_ROW_LABEL_EN
  assign in_label    = col_q <= 6'd2;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      field_q    <= '0;
      digit_q    <= '0;
      row_word_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      field_q    <= field_d;
      digit_q    <= digit_d;
      row_word_q <= row_word_d;
    end
  end

  // Next-state: fetch a row, latch it, emit its characters, advance
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    field_d    = field_q;
    digit_d    = digit_q;
    row_word_d = row_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          row_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        row_word_d = ram_out;
        col_d      = '0;
        field_d    = '0;
        digit_d    = '0;
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (emit_fire) begin
          if (col_q == LAST_COL) begin
            state_d = ST_NEXT;
          end else begin
            col_d = col_q + 6'd1;
`ifdef VGA_ROW_LABEL_EN
            if (!in_label) begin
`endif
              if (digit_q == LAST_DIGIT) begin
                digit_d = '0;
                field_d = field_q + 2'd1;
              end else begin
                digit_d = digit_q + 4'd1;
              end
`ifdef VGA_ROW_LABEL_EN
            end
`endif
          end
        end
      end
      ST_NEXT: begin
        if (row_q == LAST_ROW) begin
          state_d = ST_IDLE;
        end else begin
          row_d   = row_q + 6'd1;
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Nibble selection feeding the single encoder
  always_comb begin
    enc_nibble = field_shift[31:28];
    enc_blank  = (digit_q == LAST_DIGIT) ||
                 (row_blank && ((field_q == 2'd1) || (field_q == 2'd2)));
`ifdef VGA_ROW_LABEL_EN
    label_colon = 1'b0;
    if (col_q == 6'd0) begin
      enc_nibble = {2'b00, row_q[5:4]};
      enc_blank  = 1'b0;
    end else if (col_q == 6'd1) begin
      enc_nibble = row_q[3:0];
      enc_blank  = 1'b0;
    end else if (col_q == 6'd2) begin
      label_colon = 1'b1;
    end
`endif
  end

  vga_hex_char u_hex_char (
    .nibble (enc_nibble),
    .blank  (enc_blank),
    .ascii  (enc_ascii)
  );

  // Output character, held at zero outside the emit phase
  always_comb begin
    char_data = '0;
    if (state_q == ST_EMIT) begin
      char_data = enc_ascii;
`ifdef VGA_ROW_LABEL_EN
      if (label_colon) begin
        char_data = ASCII_COLON;
      end
`endif
    end
  end

  assign read_address = row_q;
  assign char_row     = row_q;
  assign char_col     = col_q;
  assign char_valid   = (state_q == ST_EMIT);
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = (state_q == ST_NEXT) && (row_q == LAST_ROW);

endmodule

// File: tb/tb_vga_hex_row_fetch.sv
// Self-checking bench for vga_hex_row_fetch (honours VGA_ROW_LABEL_EN).
module tb_vga_hex_row_fetch;

  localparam int NUM_ROWS = 46;
  localparam int REG_ROWS = 32;
  localparam int CPF      = 9;
`ifdef VGA_ROW_LABEL_EN
  localparam int LBL = 3;
`else
  localparam int LBL = 0;
`endif
  localparam int CPR = 4 * CPF + LBL;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic [5:0]   read_address;
  logic [127:0] ram_out;
  logic         char_valid;
  logic         char_ready;
  logic [7:0]   char_data;
  logic [5:0]   char_col;
  logic [5:0]   char_row;
  logic         busy;
  logic         frame_done;

  logic [127:0] ram [NUM_ROWS];

  int n_cmp = 0;
  int n_bad = 0;

  vga_hex_row_fetch #(.NUM_ROWS(NUM_ROWS), .REG_ROWS(REG_ROWS), .CHARS_PER_FIELD(CPF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .read_address (read_address),
    .ram_out      (ram_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_data    (char_data),
    .char_col     (char_col),
    .char_row     (char_row),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_out = (int'(read_address) < NUM_ROWS) ? ram[int'(read_address)] : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ascii(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  // Expected character from the display rules: label, fields, blanking
  function automatic logic [7:0] model_char(input int row, input int col, input logic [127:0] w);
    int c;
    int f;
    int p;
    int sh;
    c = col;
`ifdef VGA_ROW_LABEL_EN
    if (col == 0) return hex_ascii(row / 16);
    if (col == 1) return hex_ascii(row % 16);
    if (col == 2) return 8'h3A;
    c = col - 3;
`endif
    f = c / CPF;
    p = c % CPF;
    if (p == 8) return 8'h20;
    if ((f == 1 || f == 2) && row >= REG_ROWS) return 8'h20;
    sh = 124 - 32 * f - 4 * p;
    return hex_ascii(int'((w >> sh) & 128'hF));
  endfunction

  // Runs one frame, scoring every accepted beat and every stall
  task automatic run_frame(input int stall_pct, input int inject_row,
                           output int beats, output int dones);
    int er;
    int ec;
    int cyc;
    logic stalled;
    logic injected;
    logic finished;
    logic [7:0] pd;
    logic [5:0] pc;
    logic [5:0] pr;
    beats = 0; dones = 0; er = 0; ec = 0;
    stalled = 1'b0; injected = 1'b0; finished = 1'b0;
    pd = '0; pc = '0; pr = '0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      char_ready = ($urandom_range(99) >= stall_pct);
      if (frame_done) dones++;
      if (stalled) begin
        check("stall_valid", char_valid, 1);
        check("stall_data", char_data, pd);
        check("stall_col", char_col, pc);
        check("stall_row", char_row, pr);
      end
      if (char_valid && char_ready) begin
        if (er >= NUM_ROWS) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat_row", char_row, er);
          check("beat_col", char_col, ec);
          check("beat_addr", read_address, er);
          check("beat_data", char_data, model_char(er, ec, ram[er]));
        end
        beats++;
        ec++;
        if (ec == CPR) begin ec = 0; er++; end
        stalled = 1'b0;
      end else if (char_valid) begin
        stalled = 1'b1;
        pd = char_data; pc = char_col; pr = char_row;
      end else begin
        stalled = 1'b0;
      end
      if (!busy) begin finished = 1'b1; break; end
      if (inject_row >= 0 && !injected && char_valid && int'(char_row) == inject_row) begin
        frame_start = 1'b1;
        injected = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("frame_terminates", finished, 1);
  endtask

  typedef struct {
    logic [5:0] col;
    logic [7:0] ch;
  } vec_t;

  initial begin
    vec_t tbl[CPR];
    string s;
    logic [7:0] sc;
    int lat;
    int beats;
    int dones;
    int found;
    int late_done;

    // Directed vectors for row 0 of the known word
`ifdef VGA_ROW_LABEL_EN
    s = "00:00000013 DEADBEEF 3F800000 1234ABCD ";
`else
    s = "00000013 DEADBEEF 3F800000 1234ABCD ";
`endif
    for (int i = 0; i < CPR; i++) begin
      sc = s[i];
      tbl[i].col = 6'(i);
      tbl[i].ch  = sc;
    end

    for (int i = 0; i < NUM_ROWS; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    ram[0]  = 128'h0000_0013_DEAD_BEEF_3F80_0000_1234_ABCD;
    ram[40] = 128'h89AB_CDEF_FFFF_FFFF_1234_5678_0BAD_F00D;

    frame_start = 1'b0;
    char_ready  = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #2;
    check("rst_valid", char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", read_address, 0);
    check("rst_data", char_data, 0);
    check("rst_col", char_col, 0);
    check("rst_row", char_row, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known row 0 with ready tied high, plus first-beat latency
    @(negedge clk);
    frame_start = 1'b1;
    char_ready  = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    lat = 1;
    check("addr_phase_busy", busy, 1);
    check("addr_phase_addr", read_address, 0);
    while (!char_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", lat, 3);
    for (int i = 0; i < CPR; i++) begin
      check("tbl_valid", char_valid, 1);
      check("tbl_data", char_data, tbl[i].ch);
      check("tbl_col", char_col, tbl[i].col);
      check("tbl_row", char_row, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame with 50% ready stalls
    run_frame(50, -1, beats, dones);
    check("stall_frame_beats", beats, NUM_ROWS * CPR);
    check("stall_frame_done", dones, 1);
    $display("frame with stalls: %0d beats, %0d frame_done", beats, dones);

    // Full frame with a redundant frame_start at row 10
    run_frame(0, 10, beats, dones);
    check("inject_frame_beats", beats, NUM_ROWS * CPR);
    check("inject_frame_done", dones, 1);
    $display("frame with extra start: %0d beats, %0d frame_done", beats, dones);

    // Reset asserted mid-row (row 5, col 20)
    @(negedge clk);
    frame_start = 1'b1;
    char_ready  = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (char_valid && char_row == 6'd5 && char_col == 6'd20) begin found = 1; break; end
      @(negedge clk);
    end
    check("reach_row5_col20", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", char_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    check("abort_addr", read_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_done || busy) late_done++;
    end
    check("abort_quiet", late_done, 0);
    run_frame(30, -1, beats, dones);
    check("restart_frame_beats", beats, NUM_ROWS * CPR);
    check("restart_frame_done", dones, 1);
    $display("frame after abort: %0d beats, %0d frame_done", beats, dones);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
